mem_lsu: RTL and testbench

Load/store unit in the MEM stage, directly upstream of the 64-bit big-endian data memory. It turns RV64 load/store requests of byte, half, word and double size into the memory's fixed 8-byte accesses. Sub-word stores are done as read-modify-write, and load lanes are extracted with sign or zero extension. It returns one response per accepted request, and flags misaligned or out-of-range accesses without touching memory.

---
 rtl/mem_lsu_pkg.sv | 28 ++
 rtl/mem_lsu_lane.sv | 34 +++
 rtl/mem_lsu.sv | 138 +++++++++++++
 tb/tb_mem_lsu.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_lsu_pkg.sv
// Shared types and helpers for the MEM-stage load/store unit.
// Lanes are big-endian: the lowest byte address sits in the most significant byte.
package mem_lsu_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LD_RD,
        LD_RSP,
        ST_RD,
        ST_WR,
        ERR
    } state_e;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_D  = 3'b011;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;
    localparam logic [2:0] F3_WU = 3'b110;

    // Right-shift that moves a lane of 2**size bytes at byte offset off down to bit 0.
    // The result is 64 - 8*off - 8*2**size, taken modulo 64.
    function automatic logic [5:0] lane_shift(input logic [2:0] off, input logic [1:0] size);
        return 6'd0 - {off, 3'b000} - (6'd8 << size);
    endfunction

endpackage

// File: rtl/mem_lsu_lane.sv
// Lane extract/insert for one 64-bit memory word. Loads yield the sign- or zero-extended
// lane; stores yield the word with the target lane replaced by the low bits of wdata_i.
module mem_lsu_lane
    import mem_lsu_pkg::*;
(
    input  logic [2:0]  funct3_i,
    input  logic [2:0]  off_i,
    input  logic [63:0] word_i,
    input  logic [63:0] wdata_i,
    output logic [63:0] load_o,
    output logic [63:0] store_o
);

    logic [5:0]  sh;
    logic [63:0] size_mask;
    logic [63:0] lane;
    logic        neg;

    always_comb begin
        sh = lane_shift(off_i, funct3_i[1:0]);
        case (funct3_i[1:0])
            2'd0:    size_mask = 64'h0000_0000_0000_00FF;
            2'd1:    size_mask = 64'h0000_0000_0000_FFFF;
            2'd2:    size_mask = 64'h0000_0000_FFFF_FFFF;
            default: size_mask = 64'hFFFF_FFFF_FFFF_FFFF;
        endcase
        lane = (word_i >> sh) & size_mask;
        // size_mask & ~(size_mask >> 1) isolates the lane MSB
        neg = !funct3_i[2] && |(lane & size_mask & ~(size_mask >> 1));
        load_o  = neg ? (lane | ~size_mask) : lane;
        store_o = (word_i & ~(size_mask << sh)) | ((wdata_i & size_mask) << sh);
    end

endmodule

// File: rtl/mem_lsu.sv
// MEM-stage load/store unit: maps RV64 b/h/w/d accesses onto an 8-byte big-endian memory,
// doing read-modify-write for sub-word stores and rejecting bad requests before memory.
module mem_lsu
    import mem_lsu_pkg::*;
#(
    parameter int MEM_BYTES = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [2:0]  req_funct3,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    output logic        resp_valid,
    output logic        resp_err,
    output logic [63:0] resp_rdata,
    output logic [63:0] dm_address,
    output logic [63:0] dm_write_data,
    output logic        dm_MemRead,
    output logic        dm_MemWrite,
    input  logic [63:0] dm_read_data
);

    state_e      state_q, state_d;
    logic        write_q;
    logic [2:0]  f3_q;
    logic [63:0] addr_q, wdata_q;
    logic        resp_valid_q, resp_valid_d;
    logic        resp_err_q, resp_err_d;
    logic [63:0] resp_rdata_q, resp_rdata_d;
    logic        accept, misaligned, req_err;
    logic [63:0] ld_val, st_word;

    assign req_ready = (state_q == IDLE);
    assign accept    = req_valid && req_ready;

    always_comb begin
        case (req_funct3[1:0])
            2'd1:    misaligned = req_addr[0];
            2'd2:    misaligned = |req_addr[1:0];
            2'd3:    misaligned = |req_addr[2:0];
            default: misaligned = 1'b0;
        endcase
    end

    // Compare the base against MEM_BYTES-8 rather than base+8 so huge addresses cannot wrap.
    assign req_err = (req_funct3 == 3'b111) || (req_write && req_funct3[2]) || misaligned ||
                     ({req_addr[63:3], 3'b000} > 64'(MEM_BYTES - 8));

    always_comb begin
        state_d      = state_q;
        resp_valid_d = 1'b0;
        resp_err_d   = 1'b0;
        resp_rdata_d = '0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (req_err)                    state_d = ERR;
                    else if (!req_write)            state_d = LD_RD;
                    else if (req_funct3 == F3_D)    state_d = ST_WR;
                    else                            state_d = ST_RD;
                end
            end
            LD_RD:  state_d = LD_RSP;
            LD_RSP: begin
                resp_valid_d = 1'b1;
                resp_rdata_d = ld_val;
                state_d      = IDLE;
            end
            ST_RD:  state_d = ST_WR;
            ST_WR: begin
                resp_valid_d = 1'b1;
                state_d      = IDLE;
            end
            ERR: begin
                resp_valid_d = 1'b1;
                resp_err_d   = 1'b1;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= '0;
            write_q      <= 1'b0;
            f3_q         <= '0;
            addr_q       <= '0;
            wdata_q      <= '0;
        end else begin
            state_q      <= state_d;
            resp_valid_q <= resp_valid_d;
            resp_err_q   <= resp_err_d;
            resp_rdata_q <= resp_rdata_d;
            if (accept) begin
                write_q <= req_write;
                f3_q    <= req_funct3;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
            end
        end
    end

    assign resp_valid = resp_valid_q;
    assign resp_err   = resp_err_q;
    assign resp_rdata = resp_rdata_q;

    // In ST_WR the memory still presents the word fetched in ST_RD; for sd the full-width
    // mask makes the merge return req_wdata regardless of dm_read_data.
    mem_lsu_lane u_lane (
        .funct3_i (f3_q),
        .off_i    (addr_q[2:0]),
        .word_i   (dm_read_data),
        .wdata_i  (wdata_q),
        .load_o   (ld_val),
        .store_o  (st_word)
    );

    always_comb begin
        dm_address    = '0;
        dm_write_data = '0;
        dm_MemRead    = 1'b0;
        dm_MemWrite   = 1'b0;
        if (state_q inside {LD_RD, LD_RSP, ST_RD, ST_WR}) dm_address = {addr_q[63:3], 3'b000};
        if (state_q == LD_RD || state_q == ST_RD) dm_MemRead = 1'b1;
        if (state_q == ST_WR && write_q) begin
            dm_MemWrite   = 1'b1;
            dm_write_data = st_word;
        end
    end

endmodule

// File: tb/tb_mem_lsu.sv
// Bench for mem_lsu: a byte-array reference memory drives expected responses, while a
// word-wide memory model sits on the dm_* port.
module tb_mem_lsu;
    localparam int MEM_BYTES = 1024;
    localparam int WORDS     = MEM_BYTES / 8;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0, req_write = 1'b0;
    logic [2:0]  req_funct3 = '0;
    logic [63:0] req_addr = '0, req_wdata = '0;
    logic        req_ready, resp_valid, resp_err, dm_MemRead, dm_MemWrite;
    logic [63:0] resp_rdata, dm_address, dm_write_data;
    logic [63:0] dm_read_data = '0;

    logic [63:0] mem64 [0:WORDS-1];
    logic [63:0] init_words [0:WORDS-1];
    logic        preload = 1'b1;
    logic [7:0]  ref_b [0:MEM_BYTES-1];

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    mem_lsu #(.MEM_BYTES(MEM_BYTES)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_err(resp_err), .resp_rdata(resp_rdata),
        .dm_address(dm_address), .dm_write_data(dm_write_data),
        .dm_MemRead(dm_MemRead), .dm_MemWrite(dm_MemWrite), .dm_read_data(dm_read_data)
    );

    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < WORDS; i++) mem64[i] <= init_words[i];
        end else begin
            if (dm_MemWrite) mem64[dm_address[9:3]] <= dm_write_data;
            if (dm_MemRead)  dm_read_data <= mem64[dm_address[9:3]];
        end
    end

    // Reference: byte-addressed, big-endian within an access, serial request semantics.
    function automatic void model(input bit w, input logic [2:0] f3, input logic [63:0] a,
                                  input logic [63:0] wd, output bit err,
                                  output logic [63:0] rd, output int lat);
        int n, ai;
        logic [63:0] v;
        n   = 1 << f3[1:0];
        err = (f3 == 3'd7) || (w && f3 >= 3'd4) || (a % 64'(n) != 0) ||
              ((a / 8) * 8 + 8 > MEM_BYTES);
        rd  = '0;
        lat = 1;
        if (err) return;
        ai = int'(a[31:0]);
        if (w) begin
            for (int i = 0; i < n; i++) ref_b[ai + n - 1 - i] = wd[8*i +: 8];
            lat = (n == 8) ? 1 : 2;
        end else begin
            v = '0;
            for (int i = 0; i < n; i++) v = (v << 8) | 64'(ref_b[ai + i]);
            if (f3 < 3'd4 && n < 8 && v[8*n-1]) v = v | (64'hFFFF_FFFF_FFFF_FFFF << (8*n));
            rd  = v;
            lat = 2;
        end
    endfunction

    // Drives one request from an IDLE cycle and waits (bounded) for its response.
    task automatic transact(input bit w, input logic [2:0] f3, input logic [63:0] a,
                            input logic [63:0] wd, output int lat, output bit err,
                            output logic [63:0] rd, output int rd_cyc, output int wr_cyc,
                            output bit both);
        req_valid = 1'b1; req_write = w; req_funct3 = f3; req_addr = a; req_wdata = wd;
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 0; err = 1'b0; rd = '0; rd_cyc = 0; wr_cyc = 0; both = 1'b0;
        while (lat < 8) begin
            rd_cyc += int'(dm_MemRead);
            wr_cyc += int'(dm_MemWrite);
            both   |= dm_MemRead && dm_MemWrite;
            @(posedge clk); #1;
            lat++;
            if (resp_valid) begin
                err = resp_err;
                rd  = resp_rdata;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if (req_ready !== 1'b1) $display("FAIL reset_ready got %b want 1", req_ready); else n_pass++;
        n_checks++; if (resp_valid !== 1'b0 || resp_err !== 1'b0) $display("FAIL reset_resp got v=%b e=%b want 0 0", resp_valid, resp_err); else n_pass++;
        n_checks++; if (resp_rdata !== 64'd0) $display("FAIL reset_rdata got %h want 0", resp_rdata); else n_pass++;
        n_checks++; if ({dm_MemRead, dm_MemWrite, dm_address, dm_write_data} !== '0) $display("FAIL reset_dm got rd=%b wr=%b a=%h d=%h want all 0", dm_MemRead, dm_MemWrite, dm_address, dm_write_data); else n_pass++;
        preload = 1'b0;
        reset   = 1'b0;
    endtask

    typedef struct {
        bit          w;
        logic [2:0]  f3;
        logic [63:0] a;
        logic [63:0] wd;
        logic [63:0] exp;
        int          lat;
    } dir_t;

    task automatic test_directed();
        dir_t tbl[12];
        int lat, elat, rc, wc;
        bit err, eerr, both;
        logic [63:0] rd, mrd;
        tbl = '{
            '{1'b1, 3'd3, 64'h10, 64'h0102030405060708, 64'h0, 1},
            '{1'b0, 3'd3, 64'h10, 64'h0, 64'h0102030405060708, 2},
            '{1'b0, 3'd0, 64'h13, 64'h0, 64'h04, 2},
            '{1'b1, 3'd0, 64'h13, 64'h80, 64'h0, 2},
            '{1'b0, 3'd0, 64'h13, 64'h0, 64'hFFFF_FFFF_FFFF_FF80, 2},
            '{1'b0, 3'd4, 64'h13, 64'h0, 64'h80, 2},
            '{1'b0, 3'd3, 64'h10, 64'h0, 64'h0102038005060708, 2},
            '{1'b1, 3'd1, 64'h16, 64'hBEEF, 64'h0, 2},
            '{1'b0, 3'd3, 64'h10, 64'h0, 64'h010203800506BEEF, 2},
            '{1'b0, 3'd1, 64'h16, 64'h0, 64'hFFFF_FFFF_FFFF_BEEF, 2},
            '{1'b0, 3'd5, 64'h16, 64'h0, 64'hBEEF, 2},
            '{1'b0, 3'd6, 64'h14, 64'h0, 64'h0506BEEF, 2}
        };
        foreach (tbl[i]) begin
            model(tbl[i].w, tbl[i].f3, tbl[i].a, tbl[i].wd, eerr, mrd, elat);
            transact(tbl[i].w, tbl[i].f3, tbl[i].a, tbl[i].wd, lat, err, rd, rc, wc, both);
            n_checks++; if (lat !== tbl[i].lat) $display("FAIL dir%0d_latency got %0d want %0d", i, lat, tbl[i].lat); else n_pass++;
            n_checks++; if (err !== 1'b0 || rd !== tbl[i].exp) $display("FAIL dir%0d_resp got err=%b rdata=%h want err=0 rdata=%h", i, err, rd, tbl[i].exp); else n_pass++;
            n_checks++; if (wc !== int'(tbl[i].w)) $display("FAIL dir%0d_write_cycles got %0d want %0d", i, wc, int'(tbl[i].w)); else n_pass++;
            n_checks++; if (rc !== int'(!(tbl[i].w && tbl[i].f3 == 3'd3))) $display("FAIL dir%0d_read_cycles got %0d want %0d", i, rc, int'(!(tbl[i].w && tbl[i].f3 == 3'd3))); else n_pass++;
        end
    endtask

    task automatic test_errors();
        bit          ew[6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        logic [2:0]  ef[6] = '{3'd2, 3'd3, 3'd4, 3'd7, 3'd1, 3'd0};
        logic [63:0] ea[6] = '{64'h12, 64'h400, 64'h20, 64'h20, 64'h21, 64'hFFFF_FFFF_FFFF_FFF8};
        int lat, rc, wc;
        bit err, both;
        logic [63:0] rd;
        for (int i = 0; i < 6; i++) begin
            transact(ew[i], ef[i], ea[i], 64'hDEAD_BEEF_CAFE_F00D, lat, err, rd, rc, wc, both);
            n_checks++; if (lat !== 1 || err !== 1'b1 || rd !== 64'd0) $display("FAIL err%0d_resp got lat=%0d err=%b rdata=%h want lat=1 err=1 rdata=0", i, lat, err, rd); else n_pass++;
            n_checks++; if (rc !== 0 || wc !== 0) $display("FAIL err%0d_no_mem got rd=%0d wr=%0d want 0 0", i, rc, wc); else n_pass++;
        end
    endtask

    task automatic test_boundary();
        bit          bw[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        logic [2:0]  bf[4] = '{3'd3, 3'd0, 3'd3, 3'd0};
        logic [63:0] ba[4] = '{64'h3F8, 64'h3FF, 64'h3F8, 64'h400};
        int lat, elat, rc, wc;
        bit err, eerr, both;
        logic [63:0] rd, erd, wd;
        for (int i = 0; i < 4; i++) begin
            wd = {$urandom, $urandom};
            model(bw[i], bf[i], ba[i], wd, eerr, erd, elat);
            transact(bw[i], bf[i], ba[i], wd, lat, err, rd, rc, wc, both);
            n_checks++; if (lat !== elat || err !== eerr || rd !== erd) $display("FAIL bound%0d got lat=%0d err=%b rdata=%h want lat=%0d err=%b rdata=%h", i, lat, err, rd, elat, eerr, erd); else n_pass++;
        end
    endtask

    task automatic test_random();
        int lat, elat, rc, wc, bad = 0;
        bit w, err, eerr, both;
        logic [2:0]  f3;
        logic [63:0] a, wd, rd, erd;
        for (int i = 0; i < 200; i++) begin
            w  = 1'($urandom_range(0, 1));
            f3 = 3'($urandom_range(0, 7));
            a  = 64'($urandom_range(0, MEM_BYTES + 15));
            if ($urandom_range(0, 3) != 0) a = a & ~64'((1 << f3[1:0]) - 1);
            wd = {$urandom, $urandom};
            model(w, f3, a, wd, eerr, erd, elat);
            transact(w, f3, a, wd, lat, err, rd, rc, wc, both);
            n_checks++;
            if (lat !== elat || err !== eerr || rd !== erd || both) begin
                $display("FAIL rand%0d w=%b f3=%0d a=%h got lat=%0d err=%b rdata=%h rw=%b want lat=%0d err=%b rdata=%h rw=0",
                         i, w, f3, a, lat, err, rd, both, elat, eerr, erd);
                bad++;
            end else n_pass++;
        end
    endtask

    task automatic test_back_to_back();
        bit          sw[3] = '{1'b1, 1'b0, 1'b1};
        logic [2:0]  sf[3] = '{3'd2, 3'd3, 3'd0};
        logic [63:0] sa[3] = '{64'h24, 64'h20, 64'h25};
        logic [63:0] sd[3];
        logic [63:0] erd[3];
        bit          eerr[3];
        int          elat[3], acc[3];
        int cur = 0, got = 0, cyc = 0;
        bit rdy_prev, resp_prev;
        for (int i = 0; i < 3; i++) sd[i] = {$urandom, $urandom};
        req_write = sw[0]; req_funct3 = sf[0]; req_addr = sa[0]; req_wdata = sd[0];
        req_valid = 1'b1;
        rdy_prev  = req_ready;
        resp_prev = resp_valid;
        while (got < 3 && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
            if (rdy_prev && req_valid) begin
                if (cur > 0) begin
                    n_checks++; if (resp_prev !== 1'b1) $display("FAIL b2b_accept%0d_in_resp_cycle got resp_valid=%b want 1", cur, resp_prev); else n_pass++;
                end
                model(sw[cur], sf[cur], sa[cur], sd[cur], eerr[cur], erd[cur], elat[cur]);
                acc[cur] = cyc;
                cur++;
                if (cur < 3) begin
                    req_write = sw[cur]; req_funct3 = sf[cur]; req_addr = sa[cur]; req_wdata = sd[cur];
                end else req_valid = 1'b0;
            end
            if (resp_valid) begin
                n_checks++;
                if (got >= cur || cyc - acc[got] !== elat[got] || resp_err !== eerr[got] || resp_rdata !== erd[got] || req_ready !== 1'b1)
                    $display("FAIL b2b_resp%0d got lat=%0d err=%b rdata=%h ready=%b want lat=%0d err=%b rdata=%h ready=1",
                             got, cyc - acc[got], resp_err, resp_rdata, req_ready, elat[got], eerr[got], erd[got]);
                else n_pass++;
                got++;
            end else if (cur > got) begin
                n_checks++; if (req_ready !== 1'b0) $display("FAIL b2b_busy_ready cycle %0d got %b want 0", cyc, req_ready); else n_pass++;
            end
            rdy_prev  = req_ready;
            resp_prev = resp_valid;
        end
        req_valid = 1'b0;
        n_checks++; if (got !== 3) $display("FAIL b2b_responses got %0d want 3", got); else n_pass++;
        @(posedge clk); #1;
    endtask

    task automatic test_reset_midflight();
        int lat, elat, rc, wc, stray = 0;
        bit err, eerr, both;
        logic [63:0] rd, erd;
        req_valid = 1'b1; req_write = 1'b1; req_funct3 = 3'd0; req_addr = 64'h33; req_wdata = 64'h5A;
        @(posedge clk); #1;
        req_valid = 1'b0;
        n_checks++; if (dm_MemRead !== 1'b1) $display("FAIL rst_mid_in_st_rd got MemRead=%b want 1", dm_MemRead); else n_pass++;
        #2 reset = 1'b1;
        #1;
        n_checks++; if (req_ready !== 1'b1) $display("FAIL rst_mid_ready got %b want 1", req_ready); else n_pass++;
        n_checks++; if ({resp_valid, resp_err, resp_rdata} !== '0) $display("FAIL rst_mid_resp got v=%b e=%b d=%h want 0", resp_valid, resp_err, resp_rdata); else n_pass++;
        n_checks++; if ({dm_MemRead, dm_MemWrite, dm_address, dm_write_data} !== '0) $display("FAIL rst_mid_dm got rd=%b wr=%b a=%h d=%h want all 0", dm_MemRead, dm_MemWrite, dm_address, dm_write_data); else n_pass++;
        reset = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
            if (resp_valid) stray++;
        end
        n_checks++; if (stray !== 0) $display("FAIL rst_mid_no_resp got %0d responses want 0", stray); else n_pass++;
        model(1'b0, 3'd3, 64'h30, 64'h0, eerr, erd, elat);
        transact(1'b0, 3'd3, 64'h30, 64'h0, lat, err, rd, rc, wc, both);
        n_checks++; if (lat !== elat || err !== eerr || rd !== erd) $display("FAIL rst_mid_next_ld got lat=%0d err=%b rdata=%h want lat=%0d err=%b rdata=%h", lat, err, rd, elat, eerr, erd); else n_pass++;
    endtask

    initial begin
        logic [63:0] v;
        for (int i = 0; i < WORDS; i++) begin
            v = {$urandom, $urandom};
            init_words[i] = v;
            for (int j = 0; j < 8; j++) ref_b[8*i + j] = v[63 - 8*j -: 8];
        end
        test_reset();
        test_directed();
        test_errors();
        test_boundary();
        test_back_to_back();
        test_random();
        test_reset_midflight();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
